tinyrv_pin_bus: RTL

TINYRV_PIN_BUS -- requirements
Module: tinyrv_pin_bus

---
 rtl/tinyrv_pin_bus.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tinyrv_pin_bus.sv
// tinyrv_pin_bus: narrows a core-side request (ADDR_W address, DATA_W data) onto a PIN_W-wide
// multiplexed pin bus. Each transaction runs ADDR beats (LSB first), LATENCY turnaround cycles,
// DATA beats (LSB first), then a single DONE cycle that pulses ready.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   ena               advance enable; low freezes every register, outputs included
//   req, we           core request strobe and direction (1 = write)
//   addr, wdata       core address / write data, latched on acceptance
//   ready             one-cycle completion pulse
//   rdata             data from the last completed read
//   ph_out            address lane, valid during ADDR
//   dq_out, dq_in     data lanes (write / read)
//   dq_oe             dq output enable, all ones during write DATA
//   frame, wr         transaction in progress on the pins, and its direction
module tinyrv_pin_bus #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PIN_W   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic [PIN_W-1:0]  ph_out,
  output logic [PIN_W-1:0]  dq_out,
  input  logic [PIN_W-1:0]  dq_in,
  output logic [PIN_W-1:0]  dq_oe,
  output logic              frame,
  output logic              wr
);

  localparam int unsigned AB   = ADDR_W / PIN_W;
  localparam int unsigned DB   = DATA_W / PIN_W;
  localparam int unsigned MAXB = (AB > DB) ? AB : DB;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  localparam logic [CW-1:0] ALast    = CW'(AB - 1);
  localparam logic [CW-1:0] DLast    = CW'(DB - 1);
  localparam logic [3:0]    TurnLast = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  if ((ADDR_W % PIN_W) != 0 || (DATA_W % PIN_W) != 0) begin : g_width_check
    $error("tinyrv_pin_bus: ADDR_W and DATA_W must be multiples of PIN_W");
  end
  if (LATENCY > 15) begin : g_latency_check
    $error("tinyrv_pin_bus: LATENCY must be in 0..15");
  end

  typedef enum logic [2:0] {StIdle, StAddr, StTurn, StData, StDone} state_e;

  state_e            state_q;
  logic [CW-1:0]     beat_q;
  logic [3:0]        turn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] rbuf_q;

  logic [CW-1:0]     beat_nxt;
  logic [PIN_W-1:0]  addr_nxt_byte;
  logic [PIN_W-1:0]  wdata_nxt_byte;
  logic [DATA_W-1:0] rd_full;

  // Lane for the following beat; only consumed when another beat remains.
  always_comb begin
    beat_nxt       = beat_q + 1'b1;
    addr_nxt_byte  = addr_q[beat_nxt*PIN_W +: PIN_W];
    wdata_nxt_byte = wdata_q[beat_nxt*PIN_W +: PIN_W];
  end

  // Read buffer with the byte arriving this cycle merged in, so the final beat can go straight
  // into rdata on the DONE edge.
  always_comb begin
    rd_full = rbuf_q;
    rd_full[beat_q*PIN_W +: PIN_W] = dq_in;
  end

  // All pin outputs are registered: each transition loads the values for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      turn_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rbuf_q  <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      ph_out  <= '0;
      dq_out  <= '0;
      dq_oe   <= '0;
      frame   <= 1'b0;
      wr      <= 1'b0;
    end else if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            beat_q  <= '0;
            ph_out  <= addr[PIN_W-1:0];
            frame   <= 1'b1;
            wr      <= we;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (beat_q == ALast) begin
            ph_out <= '0;
            if (LATENCY > 0) begin
              turn_q  <= '0;
              state_q <= StTurn;
            end else begin
              beat_q  <= '0;
              dq_oe   <= we_q ? '1 : '0;
              dq_out  <= we_q ? wdata_q[PIN_W-1:0] : '0;
              state_q <= StData;
            end
          end else begin
            beat_q <= beat_nxt;
            ph_out <= addr_nxt_byte;
          end
        end
        StTurn: begin
          if (turn_q == TurnLast) begin
            turn_q  <= '0;
            beat_q  <= '0;
            dq_oe   <= we_q ? '1 : '0;
            dq_out  <= we_q ? wdata_q[PIN_W-1:0] : '0;
            state_q <= StData;
          end else begin
            turn_q <= turn_q + 4'd1;
          end
        end
        StData: begin
          if (!we_q) begin
            rbuf_q <= rd_full;
          end
          if (beat_q == DLast) begin
            if (!we_q) begin
              rdata <= rd_full;
            end
            beat_q  <= '0;
            dq_out  <= '0;
            dq_oe   <= '0;
            frame   <= 1'b0;
            wr      <= 1'b0;
            ready   <= 1'b1;
            state_q <= StDone;
          end else begin
            beat_q <= beat_nxt;
            if (we_q) begin
              dq_out <= wdata_nxt_byte;
            end
          end
        end
        StDone: begin
          // req is deliberately ignored here; acceptance resumes in IDLE.
          ready   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
